fpu_sum_control: RTL

Control unit (UC) that sequences the floating-point add/subtract datapath through one operation per start request. It does four things:
- registers the operands that drive the datapath;
- drives the normalizer input mux and normalizer shift selects;
- iterates normalization until the mantissa has the form 01.x, then performs rounding and re-normalization;
- captures float_R into a result register and presents it with a one-cycle done pulse.

---
 rtl/fpu_sum_pkg.sv | 28 ++
 rtl/fpu_sum_norm_decode.sv | 21 ++
 rtl/fpu_sum_control.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/fpu_sum_pkg.sv
// Shared constants for the FP add/sub control unit and its datapath.
// State encoding and the normalizer mux/shift select codes.
package fpu_sum_pkg;

   localparam int N_FLOAT  = 32;
   localparam int N_EXP    = 8;
   localparam int N_MANT   = 23;
   localparam int MAX_ITER = N_MANT + 3;

   typedef enum logic [2:0] {
      IDLE,
      ALIGN,
      NORM,
      ROUND,
      RENORM,
      CAPTURE,
      DONE
   } state_e;

   localparam logic [1:0] MUX_ALU   = 2'b00;
   localparam logic [1:0] MUX_FB    = 2'b01;
   localparam logic [1:0] MUX_ROUND = 2'b10;

   localparam logic [1:0] NRM_HOLD  = 2'b00;
   localparam logic [1:0] NRM_RIGHT = 2'b01;
   localparam logic [1:0] NRM_LEFT  = 2'b10;

endpackage

// File: rtl/fpu_sum_norm_decode.sv
// Maps the integer bits at the normalizer input to a shift request.
// 01.x is normalized; 1x.x needs a right shift; 00.x a left shift.
module fpu_sum_norm_decode
   import fpu_sum_pkg::*;
(
   input  logic [1:0] antes_virgula_i,
   output logic [1:0] shift_o,
   output logic       normalized_o
);

   always_comb begin
      shift_o      = NRM_HOLD;
      normalized_o = 1'b0;
      unique case (1'b1)
         antes_virgula_i[1]:        shift_o      = NRM_RIGHT;
         antes_virgula_i == 2'b01:  normalized_o = 1'b1;
         antes_virgula_i == 2'b00:  shift_o      = NRM_LEFT;
      endcase
   end

endmodule

// File: rtl/fpu_sum_control.sv
// Sequencer for the FP add/sub datapath: align, normalize, round,
// re-normalize, capture, one operation per accepted start.
module fpu_sum_control
   import fpu_sum_pkg::*;
#(
   parameter int N_float  = 32,
   parameter int N_exp    = 8,
   parameter int N_mant   = 23,
   parameter int MAX_ITER = N_mant + 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [N_float-1:0] float_A_in,
   input  logic [N_float-1:0] float_B_in,
   output logic [N_float-1:0] float_A,
   output logic [N_float-1:0] float_B,
   input  logic [N_exp-1:0]   diferenca_exp,
   input  logic [1:0]         antes_virgula,
   output logic [1:0]         sel_mux_normalizer,
   output logic [1:0]         sel_normalizer,
   input  logic [N_float-1:0] float_R,
   output logic [N_float-1:0] result,
   output logic               busy,
   output logic               done,
   output logic               iter_timeout
);

   localparam int CW = $clog2(MAX_ITER + 1);
   localparam logic [CW-1:0] LAST = CW'(MAX_ITER - 1);

   state_e             state_q;
   logic [CW-1:0]      cnt_q;
   logic               carry_q;
   logic [N_float-1:0] fa_q;
   logic [N_float-1:0] fb_q;
   logic [N_float-1:0] res_q;
   logic [1:0]         mux_q;
   logic [1:0]         nrm_q;
   logic               busy_q;
   logic               done_q;
   logic               tmo_q;

   logic [1:0]         shift;
   logic               normd;

   fpu_sum_norm_decode u_dec (
      .antes_virgula_i (antes_virgula),
      .shift_o         (shift),
      .normalized_o    (normd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         fa_q    <= '0;
         fb_q    <= '0;
         res_q   <= '0;
         mux_q   <= MUX_ALU;
         nrm_q   <= NRM_HOLD;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         tmo_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= ALIGN;
                  busy_q  <= 1'b1;
                  fa_q    <= float_A_in;
                  fb_q    <= float_B_in;
                  cnt_q   <= '0;
                  carry_q <= 1'b0;
                  tmo_q   <= 1'b0;
               end
            end
            ALIGN: begin
               state_q <= NORM;
               mux_q   <= MUX_ALU;
               nrm_q   <= NRM_HOLD;
            end
            NORM: begin
               cnt_q <= cnt_q + 1'b1;
               // a zero mantissa never reaches 01.x; bail out at the bound
               if (normd || cnt_q == LAST) begin
                  state_q <= ROUND;
                  mux_q   <= MUX_ROUND;
                  nrm_q   <= NRM_HOLD;
                  if (!normd) tmo_q <= 1'b1;
               end else begin
                  mux_q <= MUX_FB;
                  nrm_q <= shift;
               end
            end
            ROUND: begin
               state_q <= RENORM;
            end
            RENORM: begin
               if (!carry_q && shift == NRM_RIGHT) begin
                  carry_q <= 1'b1;
                  nrm_q   <= NRM_RIGHT;
               end else begin
                  state_q <= CAPTURE;
                  mux_q   <= MUX_ALU;
                  nrm_q   <= NRM_HOLD;
               end
            end
            CAPTURE: begin
               state_q <= DONE;
               res_q   <= float_R;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   a_dexp_known: assert property (@(posedge clk) disable iff (!rst_n)
      (state_q == ALIGN) |-> !$isunknown(diferenca_exp));

   a_no_rsvd: assert property (@(posedge clk) disable iff (!rst_n)
      sel_normalizer != 2'b11);

   assign float_A            = fa_q;
   assign float_B            = fb_q;
   assign result             = res_q;
   assign sel_mux_normalizer = mux_q;
   assign sel_normalizer     = nrm_q;
   assign busy               = busy_q;
   assign done               = done_q;
   assign iter_timeout       = tmo_q;

endmodule
